// File: rtl/rx_output_guard.sv
// Output guard between serial_rx and the OUT[3:0] pins: blanks outputs until the link is
// stable and limits per-channel on-time. Optional sticky fault latch: RX_GUARD_LATCH_EN.
module rx_output_guard #(
    parameter int unsigned MAX_ON_CYC  = 30000,
    parameter int unsigned MIN_OFF_CYC = 6000,
    parameter int unsigned RELOCK_CYC  = 60000
) (
    input  logic       i_clk,
    input  logic       i_res_n,
    input  logic [3:0] i_data,
    input  logic       i_my_lock,
    input  logic       i_sfp_los,
    output logic [3:0] o_data,
    output logic       o_active,
    output logic       o_fault,
    output logic [7:0] o_trip_cnt
);
    localparam int unsigned CW  = 16;
    localparam int unsigned NCH = 4;
    localparam logic [CW-1:0] HOLD_LAST = CW'(RELOCK_CYC - 1);
    localparam logic [CW-1:0] ON_LAST   = CW'(MAX_ON_CYC - 1);
    localparam logic [CW-1:0] OFF_LAST  = CW'(MIN_OFF_CYC - 1);

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        HOLD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  hold_cnt, hold_cnt_nxt;
    logic [CW-1:0]  on_cnt      [NCH];
    logic [CW-1:0]  on_cnt_nxt  [NCH];
    logic [CW-1:0]  off_cnt     [NCH];
    logic [CW-1:0]  off_cnt_nxt [NCH];
    logic [NCH-1:0] trip, trip_nxt, trip_set;
    logic [2:0]     new_trips;
    logic [8:0]     trip_sum;
    logic [7:0]     trip_cnt_nxt;
    logic           link_ok, run_ok, freeze, force_blank;

    assign link_ok = i_my_lock & ~i_sfp_los;
    assign run_ok  = (state == RUN) & link_ok;

`ifdef RX_GUARD_LATCH_EN
    // Sticky fault: once any channel trips, only reset brings the outputs back.
    logic fault_latch;
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n)
            fault_latch <= 1'b0;
        else if (|trip_set)
            fault_latch <= 1'b1;
    end
    assign freeze      = fault_latch;
    assign force_blank = fault_latch | (|trip_set);
`else
    assign freeze      = 1'b0;
    assign force_blank = 1'b0;
`endif

    // Global link/relock state machine.
    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        if (!link_ok || force_blank) begin
            state_nxt    = BLANK;
            hold_cnt_nxt = '0;
        end else begin
            case (state)
                BLANK: begin
                    hold_cnt_nxt = '0;
                    state_nxt    = HOLD;
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        if (i_data == 4'h0)
                            state_nxt = RUN;
                    end else begin
                        hold_cnt_nxt = hold_cnt + CW'(1);
                    end
                end
                RUN:     hold_cnt_nxt = '0;
                default: state_nxt = BLANK;
            endcase
        end
    end

    // Per-channel on-time limit and off-time re-arm.
    always_comb begin
        for (int n = 0; n < int'(NCH); n++) begin
            on_cnt_nxt[n]  = on_cnt[n];
            off_cnt_nxt[n] = off_cnt[n];
            trip_nxt[n]    = trip[n];
            trip_set[n]    = 1'b0;
            if (!run_ok) begin
                if (!freeze) begin
                    on_cnt_nxt[n]  = '0;
                    off_cnt_nxt[n] = '0;
                    trip_nxt[n]    = 1'b0;
                end
            end else if (!trip[n]) begin
                off_cnt_nxt[n] = '0;
                if (!i_data[n]) begin
                    on_cnt_nxt[n] = '0;
                end else if (on_cnt[n] == ON_LAST) begin
                    on_cnt_nxt[n] = '0;
                    trip_nxt[n]   = 1'b1;
                    trip_set[n]   = 1'b1;
                end else begin
                    on_cnt_nxt[n] = on_cnt[n] + CW'(1);
                end
            end else begin
                on_cnt_nxt[n] = '0;
                if (i_data[n]) begin
                    off_cnt_nxt[n] = '0;
                end else if (off_cnt[n] == OFF_LAST) begin
                    off_cnt_nxt[n] = '0;
                    trip_nxt[n]    = 1'b0;
                end else begin
                    off_cnt_nxt[n] = off_cnt[n] + CW'(1);
                end
            end
        end
    end

    // Saturating trip-event counter; simultaneous trips each count.
    always_comb begin
        new_trips = '0;
        for (int n = 0; n < int'(NCH); n++)
            new_trips = new_trips + 3'(trip_set[n]);
        trip_sum     = 9'(o_trip_cnt) + 9'(new_trips);
        trip_cnt_nxt = trip_sum[8] ? 8'hFF : trip_sum[7:0];
    end

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            state      <= BLANK;
            hold_cnt   <= '0;
            trip       <= '0;
            o_data     <= '0;
            o_active   <= 1'b0;
            o_fault    <= 1'b0;
            o_trip_cnt <= '0;
            for (int n = 0; n < int'(NCH); n++) begin
                on_cnt[n]  <= '0;
                off_cnt[n] <= '0;
            end
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_cnt_nxt;
            trip       <= trip_nxt;
            o_data     <= i_data & {NCH{run_ok}} & ~trip & ~{NCH{freeze}};
            o_active   <= (state_nxt == RUN);
            o_fault    <= (|trip_nxt) | force_blank;
            o_trip_cnt <= trip_cnt_nxt;
            for (int n = 0; n < int'(NCH); n++) begin
                on_cnt[n]  <= on_cnt_nxt[n];
                off_cnt[n] <= off_cnt_nxt[n];
            end
        end
    end
endmodule

// File: tb/tb_rx_output_guard.sv
// Randomized and directed bench for rx_output_guard against a cycle-count reference model.
module tb_rx_output_guard;
    localparam int unsigned MAX_ON  = 10;
    localparam int unsigned MIN_OFF = 5;
    localparam int unsigned RELOCK  = 8;
`ifdef RX_GUARD_LATCH_EN
    localparam bit LATCH_MODE = 1'b1;
`else
    localparam bit LATCH_MODE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic [3:0] i_data = 4'h0;
    logic       i_my_lock = 1'b1;
    logic       i_sfp_los = 1'b0;
    logic [3:0] o_data;
    logic       o_active;
    logic       o_fault;
    logic [7:0] o_trip_cnt;

    int vectors = 0;
    int errors  = 0;

    rx_output_guard #(
        .MAX_ON_CYC (MAX_ON),
        .MIN_OFF_CYC(MIN_OFF),
        .RELOCK_CYC (RELOCK)
    ) dut (
        .i_clk     (clk),
        .i_res_n   (res_n),
        .i_data    (i_data),
        .i_my_lock (i_my_lock),
        .i_sfp_los (i_sfp_los),
        .o_data    (o_data),
        .o_active  (o_active),
        .o_fault   (o_fault),
        .o_trip_cnt(o_trip_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: consecutive good-link cycles, and per channel the number of
    // consecutive passed-high cycles and consecutive low cycles while tripped.
    int unsigned m_good;
    bit          m_run;
    bit          m_latch;
    bit [3:0]    m_trip;
    int unsigned m_on  [4];
    int unsigned m_off [4];
    logic [3:0]  e_data;
    logic        e_active, e_fault;
    logic [7:0]  e_cnt;

    wire [13:0] got_v = {o_data, o_active, o_fault, o_trip_cnt};
    wire [13:0] exp_v = {e_data, e_active, e_fault, e_cnt};

    task automatic model_reset();
        m_good = 0; m_run = 0; m_latch = 0; m_trip = '0;
        for (int n = 0; n < 4; n++) begin m_on[n] = 0; m_off[n] = 0; end
        e_data = '0; e_active = 0; e_fault = 0; e_cnt = '0;
    endtask

    task automatic model_step(input logic [3:0] d, input logic lk, input logic los);
        bit ok;
        int unsigned fresh, total;
        ok = lk && !los;
        fresh = 0;
        m_good = ok ? ((m_good < 100000) ? m_good + 1 : m_good) : 0;
        e_data = (m_run && ok) ? (d & ~m_trip) : 4'h0;
        if (!ok) begin
            m_trip = '0;
            for (int n = 0; n < 4; n++) begin m_on[n] = 0; m_off[n] = 0; end
        end else if (m_run) begin
            for (int n = 0; n < 4; n++) begin
                if (!m_trip[n]) begin
                    m_on[n] = d[n] ? m_on[n] + 1 : 0;
                    if (m_on[n] == MAX_ON) begin
                        m_trip[n] = 1'b1; m_on[n] = 0; m_off[n] = 0; fresh++;
                    end
                end else begin
                    m_off[n] = d[n] ? 0 : m_off[n] + 1;
                    if (m_off[n] == MIN_OFF) begin m_trip[n] = 1'b0; m_off[n] = 0; end
                end
            end
        end
        total = int'(e_cnt) + fresh;
        e_cnt = (total > 255) ? 8'd255 : 8'(total);
        m_run = ok && (m_run || (m_good >= RELOCK + 1 && d == 4'h0));
        if (LATCH_MODE && fresh != 0) m_latch = 1'b1;
        if (m_latch) m_run = 1'b0;
        e_active = m_run;
        e_fault  = (|m_trip) || m_latch;
    endtask

    // One clock: drive at the falling edge, model the rising edge, return at the next falling edge.
    task automatic step(input logic [3:0] d, input logic lk, input logic los);
        i_data = d; i_my_lock = lk; i_sfp_los = los;
        @(posedge clk);
        model_step(d, lk, los);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        res_n = 1'b0; i_data = 4'h0; i_my_lock = 1'b1; i_sfp_los = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #2 res_n = 1'b1;
    endtask

    task automatic test_reset();
        res_n = 1'b0; i_data = 4'hF; i_my_lock = 1'b1; i_sfp_los = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if (got_v !== 14'h0) begin
            errors++; $display("FAIL reset_state: got %h required %h", got_v, 14'h0);
        end
        i_data = 4'h0;
        #2 res_n = 1'b1;
    endtask

    task automatic test_relock();
        int first_active = -1;
        for (int c = 1; c <= 12; c++) begin
            step(4'h0, 1'b1, 1'b0);
            vectors++;
            if (got_v !== exp_v) begin
                errors++; $display("FAIL relock cyc %0d: got %h required %h", c, got_v, exp_v);
            end
            if (o_active && first_active < 0) first_active = c;
        end
        vectors++;
        if (first_active != int'(RELOCK) + 1) begin
            errors++; $display("FAIL relock_latency: got %0d required %0d", first_active, RELOCK + 1);
        end
    endtask

    task automatic test_short_pulse();
        int highs = 0;
        for (int c = 0; c < 10; c++) begin
            step((c < 6) ? 4'h1 : 4'h0, 1'b1, 1'b0);
            vectors++;
            if (got_v !== exp_v) begin
                errors++; $display("FAIL short_pulse cyc %0d: got %h required %h", c, got_v, exp_v);
            end
            if (o_data[0]) highs++;
        end
        vectors++;
        if (highs != 6 || o_fault !== 1'b0 || o_trip_cnt !== 8'd0) begin
            errors++;
            $display("FAIL short_pulse_len: got highs=%0d fault=%b cnt=%0d required 6/0/0", highs, o_fault, o_trip_cnt);
        end
    endtask

    task automatic test_trip();
        int highs = 0;
        for (int c = 0; c < 20; c++) begin
            step(4'h2, 1'b1, 1'b0);
            vectors++;
            if (got_v !== exp_v) begin
                errors++; $display("FAIL trip cyc %0d: got %h required %h", c, got_v, exp_v);
            end
            if (o_data[1]) highs++;
        end
        vectors++;
        if (highs != int'(MAX_ON) || o_fault !== 1'b1 || o_trip_cnt !== 8'd1) begin
            errors++;
            $display("FAIL trip_len: got highs=%0d fault=%b cnt=%0d required %0d/1/1", highs, o_fault, o_trip_cnt, MAX_ON);
        end
    endtask

    task automatic test_recovery();
        logic [3:0] pat [14] = '{4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0,
                                 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0};
        for (int c = 0; c < 14; c++) begin
            step(pat[c], 1'b1, 1'b0);
            vectors++;
            if (got_v !== exp_v) begin
                errors++; $display("FAIL recovery cyc %0d: got %h required %h", c, got_v, exp_v);
            end
            if (c == 7) begin
                vectors++;
                if (o_fault !== 1'b1) begin
                    errors++; $display("FAIL recovery_early: got fault=%b required 1", o_fault);
                end
            end
            if (c == 8) begin
                vectors++;
                if (o_fault !== LATCH_MODE) begin
                    errors++; $display("FAIL recovery_clear: got fault=%b required %b", o_fault, LATCH_MODE);
                end
            end
            if (c == 9) begin
                vectors++;
                if (o_data[1] !== !LATCH_MODE) begin
                    errors++; $display("FAIL recovery_pass: got o_data[1]=%b required %b", o_data[1], !LATCH_MODE);
                end
            end
        end
    endtask

    task automatic test_link_drop();
        for (int c = 0; c < 20; c++) begin
            if (c < 3)       step(4'hF, 1'b1, 1'b0);
            else if (c == 3) step(4'hF, 1'b0, 1'b0);
            else if (c < 16) step(4'hF, 1'b1, 1'b0);
            else             step(4'h0, 1'b1, 1'b0);
            vectors++;
            if (got_v !== exp_v) begin
                errors++; $display("FAIL link_drop cyc %0d: got %h required %h", c, got_v, exp_v);
            end
            if (c == 3) begin
                vectors++;
                if (o_data !== 4'h0 || o_active !== 1'b0) begin
                    errors++; $display("FAIL link_drop_blank: got data=%h active=%b required 0/0", o_data, o_active);
                end
            end
            if (c == 15) begin
                vectors++;
                if (o_active !== 1'b0) begin
                    errors++; $display("FAIL link_drop_wait_zero: got active=%b required 0", o_active);
                end
            end
        end
    endtask

    task automatic test_multi_trip();
        for (int c = 0; c < 12; c++) begin
            step(4'hF, 1'b1, 1'b0);
            vectors++;
            if (got_v !== exp_v) begin
                errors++; $display("FAIL multi_trip cyc %0d: got %h required %h", c, got_v, exp_v);
            end
        end
        vectors++;
        if (o_trip_cnt !== 8'd4 || o_data !== 4'h0 || o_fault !== 1'b1) begin
            errors++;
            $display("FAIL multi_trip_count: got cnt=%0d data=%h fault=%b required 4/0/1", o_trip_cnt, o_data, o_fault);
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 70; k++) begin
            for (int c = 0; c < 15; c++) begin
                step((c < 10) ? 4'hF : 4'h0, 1'b1, 1'b0);
                vectors++;
                if (got_v !== exp_v) begin
                    errors++; $display("FAIL saturate it %0d cyc %0d: got %h required %h", k, c, got_v, exp_v);
                end
            end
        end
        vectors++;
        if (o_trip_cnt !== (LATCH_MODE ? 8'd4 : 8'd255)) begin
            errors++; $display("FAIL saturate_final: got %0d required %0d", o_trip_cnt, LATCH_MODE ? 4 : 255);
        end
    endtask

    task automatic test_random();
        bit [3:0] lvl = '0;
        int unsigned left [4] = '{0, 0, 0, 0};
        int unsigned drop_left = 0;
        bit drop_los = 0;
        logic lk, los;
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 4; n++) begin
                if (left[n] == 0) begin
                    lvl[n]  = 1'($urandom_range(0, 1));
                    left[n] = $urandom_range(1, 24);
                end
                left[n]--;
            end
            if (drop_left == 0 && $urandom_range(0, 249) == 0) begin
                drop_left = $urandom_range(1, 3);
                drop_los  = 1'($urandom_range(0, 1));
            end
            lk = 1'b1; los = 1'b0;
            if (drop_left != 0) begin
                if (drop_los) los = 1'b1; else lk = 1'b0;
                drop_left--;
            end
            step(lvl, lk, los);
            vectors++;
            if (got_v !== exp_v) begin
                errors++; $display("FAIL random cyc %0d: got %h required %h", c, got_v, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 10; c++) begin
            step((c < 4) ? 4'h8 : 4'hC, 1'b1, 1'b0);
            vectors++;
            if (got_v !== exp_v) begin
                errors++; $display("FAIL async_setup cyc %0d: got %h required %h", c, got_v, exp_v);
            end
        end
        vectors++;
        if (o_data[2] !== 1'b1 || o_trip_cnt !== 8'd1) begin
            errors++; $display("FAIL async_pre: got data=%h cnt=%0d required bit2=1 cnt=1", o_data, o_trip_cnt);
        end
        #2 res_n = 1'b0;
        #1;
        vectors++;
        if (got_v !== 14'h0) begin
            errors++; $display("FAIL async_reset: got %h required %h", got_v, 14'h0);
        end
        @(negedge clk);
        apply_reset();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_relock();
        test_short_pulse();
        test_trip();
        test_recovery();
        apply_reset();
        test_relock();
        test_link_drop();
        apply_reset();
        test_relock();
        test_multi_trip();
        test_saturate();
        apply_reset();
        test_random();
        apply_reset();
        test_relock();
        test_async_reset();
        test_relock();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/rx_output_guard.md
RX_OUTPUT_GUARD -- requirements
Module: rx_output_guard

Placement: between serial_rx outputs (o_data, o_my_lock) and the OUT[3:0] pins; serial_rx drives its inputs in the same clock domain.

Interface
REQ-001 SHALL have parameter MAX_ON_CYC, default 30000 (500 us at 60 MHz): the maximum number of consecutive cycles a channel may stay high.
REQ-002 SHALL have parameter MIN_OFF_CYC, default 6000 (100 us): the number of consecutive cycles a tripped channel's input must stay low before that channel re-arms.
REQ-003 SHALL have parameter RELOCK_CYC, default 60000 (1 ms): the number of consecutive cycles the link must be good before the outputs are enabled.
REQ-004 SHALL have port i_clk, input, 1 bit: 60 MHz system clock (CLK_60M[0]); the block's only clock.
REQ-005 SHALL have port i_res_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port i_data, input, 4 bits: received gate channels from serial_rx.
REQ-007 SHALL have port i_my_lock, input, 1 bit: 8b10b symbol lock from serial_rx.
REQ-008 SHALL have port i_sfp_los, input, 1 bit: SFP loss of signal, high = loss.
REQ-009 SHALL have port o_data, output, 4 bits: guarded channels driven to OUT[3:0].
REQ-010 SHALL have port o_active, output, 1 bit: high while the state is RUN.
REQ-011 SHALL have port o_fault, output, 1 bit: high while any channel is tripped (or latched, see Configuration).
REQ-012 SHALL have port o_trip_cnt, output, 8 bits: count of trip events, saturating at 255.

Function
REQ-013 SHALL define link_ok = i_my_lock AND NOT i_sfp_los; inputs are already synchronous, so no synchronizer SHALL be added.
REQ-014 SHALL implement the global states BLANK, HOLD and RUN, using a 16-bit hold counter.
REQ-015 BLANK: hold counter = 0; if link_ok, go to HOLD.
REQ-016 HOLD: increment the hold counter each cycle, saturating at RELOCK_CYC-1.
REQ-017 HOLD: when the hold counter is RELOCK_CYC-1 and i_data == 4'h0, go to RUN; if i_data != 0 at that point, stay in HOLD (counter saturated) until i_data == 0.
REQ-018 Any state: NOT link_ok SHALL force BLANK on the next edge; this takes priority over every other transition.
REQ-019 o_data SHALL be registered with one cycle of latency: o_data[n] = i_data[n] AND (state==RUN) AND NOT trip[n], all evaluated on the previous cycle.
REQ-020 Each channel SHALL have a 16-bit on counter that increments while state==RUN and i_data[n] is high, and clears when i_data[n] is low or state!=RUN.
REQ-021 When a channel's on counter reaches MAX_ON_CYC-1 while i_data[n] is still high, trip[n] SHALL set, so o_data[n] is high for exactly MAX_ON_CYC cycles.
REQ-022 A tripped channel SHALL hold trip[n] set; a 16-bit off counter counts consecutive cycles with i_data[n] low, and resets to 0 whenever i_data[n] goes high.
REQ-023 When the off counter reaches MIN_OFF_CYC-1, trip[n] SHALL clear; the channel outputs again only on the next high input cycle.
REQ-024 Entering BLANK SHALL clear all on counters, all off counters and all trip bits, except when they are latched under RX_GUARD_LATCH_EN.
REQ-025 o_fault = OR of trip[3:0], registered.
REQ-026 o_trip_cnt SHALL increment once per trip rising edge; if several channels trip in the same cycle, it adds their number, saturating at 255.
REQ-027 Channels SHALL be independent; a trip on one channel SHALL NOT affect the others.

Reset
REQ-028 Asserting i_res_n low SHALL asynchronously force: state=BLANK, all counters=0, trip=4'h0, o_data=4'h0, o_active=0, o_fault=0, o_trip_cnt=0.
REQ-029 If reset is asserted while a channel is high, o_data SHALL go low immediately, without waiting for a clock edge.
REQ-030 After reset is released, the block SHALL pass through HOLD for the full RELOCK_CYC cycles before any output goes high.

Configuration
REQ-031 Macro RX_GUARD_LATCH_EN defined: any trip SHALL set a sticky fault latch.
REQ-032 With the latch set: o_data = 4'h0 on all channels, o_fault = 1, o_active = 0 (state is forced to BLANK); only i_res_n clears it, and link_ok or off-timeout SHALL have no effect.
REQ-033 Macro RX_GUARD_LATCH_EN undefined: per-channel auto-recovery SHALL apply as in REQ-022/023, and no latch logic SHALL exist.

Verification
REQ-034 (MAX_ON=10, MIN_OFF=5, RELOCK=8) Release reset with link_ok=1 and i_data=0 -> o_active rises 9 cycles after the first edge; o_data stays 0 throughout.
REQ-035 In RUN, i_data[0] high for 6 cycles -> o_data[0] high for 6 cycles with 1 cycle of lag; o_fault=0; o_trip_cnt=0.
REQ-036 In RUN, i_data[1] held high for 20 cycles -> o_data[1] high for exactly 10 cycles, o_fault=1, o_trip_cnt=1.
REQ-037 After the REQ-036 trip, with the macro undefined: i_data[1] low for 3 cycles, high for 1, then low for 5 -> trip clears only after the 5-cycle run; the next high pulse passes. With the macro defined: the fault stays and o_data stays 0 until reset.
REQ-038 In RUN with i_data=4'hF, drop i_my_lock for 1 cycle -> o_data=0 on the next edge and state=BLANK; after relock, RUN is not re-entered until i_data=0 and 8 good cycles have passed.
REQ-039 Assert i_res_n low mid-pulse with o_data[2] high -> o_data goes to 0 asynchronously and o_trip_cnt=0.
